// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data load/store) sharing one memory port.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   starve_cnt;
  logic            grant_d, grant_if;
  logic            done_if, done_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || starve_cnt < LIMIT_C)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req && (!d_req || starve_cnt == LIMIT_C)) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        // No timeout: a busy state waits as long as memory needs.
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_if = (state == BUSY_IF) && mem_ready;
  assign done_d  = (state == BUSY_D)  && mem_ready;

  // Derived from state so that async reset drops it immediately.
  assign mem_req = (state != IDLE);
  assign stall   = (d_req & ~d_valid) | (if_req & ~if_valid);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state    <= state_nxt;
      if_valid <= done_if;
      d_valid  <= done_d;

      if (done_if) if_rdata <= mem_rdata;
      if (done_d)  d_rdata  <= mem_rdata;

      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_wstrb;
        if (!if_req)
          starve_cnt <= '0;
        else if (starve_cnt != LIMIT_C)
          starve_cnt <= starve_cnt + CW'(1);
      end else if (grant_if) begin
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wstrb  <= '0;
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory accesses and
// completions; a memory model and a response monitor pop and compare them.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        stall;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  typedef struct packed {
    logic        is_if;
    logic [31:0] rdata;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   wait_states = 0;
  logic idle_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: mem_word = 32'h00500093;
      32'h300: mem_word = 32'h12345678;
      default: mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wdata; a.wstrb = wstrb;
    acc_q.push_back(a);
  endtask

  task automatic push_rsp(input logic is_if, input logic [31:0] rdata);
    rsp_t r;
    r.is_if = is_if; r.rdata = rdata;
    rsp_q.push_back(r);
  endtask

  task automatic wait_valid(input bit want_if, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (want_if ? if_valid : d_valid) break;
    end
    check(name, 32'(i < budget), 32'd1);
  endtask

  // Memory model: answers after wait_states cycles and checks each completed access.
  initial begin
    int   cnt;
    acc_t e;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        cnt = 0;
        mem_ready = idle_ready;
        mem_rdata = 32'hBAD0BAD0;
      end else begin
        mem_ready = (cnt >= wait_states);
        mem_rdata = mem_word(mem_addr);
        cnt++;
        if (mem_ready) begin
          if (acc_q.size() == 0) begin
            check("unexpected_access", 32'(mem_req), 32'd0);
          end else begin
            e = acc_q.pop_front();
            check("acc_we", 32'(mem_we), 32'(e.we));
            check("acc_addr", mem_addr, e.addr);
            check("acc_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
            if (e.we) check("acc_wdata", mem_wdata, e.wdata);
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (if_valid && d_valid) begin
        check("both_valid", 32'(if_valid & d_valid), 32'd0);
      end else if (if_valid || d_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_valid", 32'(if_valid | d_valid), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_kind", 32'(if_valid), 32'(e.is_if));
          check("rsp_rdata", if_valid ? if_rdata : d_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int held, seen, cnt;
    bit got, flag;

    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_d_valid", 32'(d_valid), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_stall", 32'(stall), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests from reset: data first, fetch after d_valid.
    @(negedge clk);
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    push_acc(1, 32'h200, 32'hDEADBEEF, 4'hF);
    push_acc(0, 32'h104, 0, 4'h0);
    push_rsp(0, 32'hC0DE0200);
    push_rsp(1, 32'hC0DE0104);
    @(negedge clk);
    check("t1_first_req", 32'(mem_req), 1);
    check("t1_first_we", 32'(mem_we), 1);
    check("t1_first_addr", mem_addr, 32'h200);
    wait_valid(0, 10, "t1_d_done");
    d_req = 0; d_we = 0;
    wait_valid(1, 10, "t1_if_done");
    if_req = 0;

    // Lone fetch, zero wait states.
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    push_acc(0, 32'h100, 0, 4'h0);
    push_rsp(1, 32'h00500093);
    flag = 0; got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) flag = 1;
      if (if_valid) begin got = 1; break; end
    end
    check("t2_done", 32'(got), 1);
    check("t2_we_low", 32'(flag), 0);
    if_req = 0;
    @(negedge clk);
    check("t2_valid_one_cycle", 32'(if_valid), 0);
    check("t2_rdata_hold", if_rdata, 32'h00500093);

    // Load with five wait states.
    wait_states = 5;
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h300; d_wdata = 0; d_wstrb = 0;
    push_acc(0, 32'h300, 0, 4'h0);
    push_rsp(0, 32'h12345678);
    held = 0; flag = 1; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_valid) begin got = 1; break; end
      if (!stall) flag = 0;
      if (mem_req && mem_addr == 32'h300) held++;
    end
    check("t3_done", 32'(got), 1);
    check("t3_addr_stable_cycles", 32'(held), 6);
    check("t3_stall_held", 32'(flag), 1);
    check("t3_stall_released", 32'(stall), 0);
    check("t3_rdata", d_rdata, 32'h12345678);
    d_req = 0;
    wait_states = 0;

    // Starvation: both held -> 4 data, 1 fetch, then data again.
    @(negedge clk);
    if_req = 1; if_addr = 32'h400;
    d_req = 1; d_we = 0; d_addr = 32'h500; d_wstrb = 0;
    for (int i = 0; i < 4; i++) begin
      push_acc(0, 32'h500, 0, 4'h0);
      push_rsp(0, 32'hC0DE0500);
    end
    push_acc(0, 32'h400, 0, 4'h0);
    push_rsp(1, 32'hC0DE0400);
    push_acc(0, 32'h500, 0, 4'h0);
    push_rsp(0, 32'hC0DE0500);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_valid || d_valid) seen++;
      if (seen == 6) break;
    end
    if_req = 0; d_req = 0;
    check("t4_completions", 32'(seen), 6);

    // Data request pulsed while fetch is busy is withdrawn.
    wait_states = 3;
    @(negedge clk);
    if_req = 1; if_addr = 32'h600;
    push_acc(0, 32'h600, 0, 4'h0);
    push_rsp(1, 32'hC0DE0600);
    @(negedge clk);
    check("t5_busy_if", 32'(mem_req), 1);
    d_req = 1; d_we = 1; d_addr = 32'h680; d_wdata = 32'h11111111; d_wstrb = 4'hF;
    @(negedge clk);
    d_req = 0; d_we = 0;
    wait_valid(1, 10, "t5_if_done");
    if_req = 0;
    cnt = 0; flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) cnt++;
      if (d_valid) flag = 1;
    end
    check("t5_no_data_access", 32'(cnt), 0);
    check("t5_no_d_valid", 32'(flag), 0);
    wait_states = 0;

    // mem_ready while idle is ignored.
    idle_ready = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_valid || d_valid || mem_req) cnt++;
    end
    idle_ready = 1'b0;
    check("t6_idle_ready_ignored", 32'(cnt), 0);

    // Reset in the middle of a store.
    wait_states = 100;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'h55AA55AA; d_wstrb = 4'h3;
    @(negedge clk);
    check("t7_busy_d", 32'(mem_req), 1);
    check("t7_busy_we", 32'(mem_we), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_mem_req", 32'(mem_req), 0);
    check("t7_async_mem_we", 32'(mem_we), 0);
    check("t7_async_mem_addr", mem_addr, 0);
    d_req = 0; d_we = 0;
    wait_states = 0;
    flag = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_valid) flag = 1;
    end
    check("t7_no_d_valid", 32'(flag), 0);
    check("t7_if_rdata_cleared", if_rdata, 0);
    check("t7_d_rdata_cleared", d_rdata, 0);
    rst_n = 1'b1;
    if_req = 1; if_addr = 32'h100;
    push_acc(0, 32'h100, 0, 4'h0);
    push_rsp(1, 32'h00500093);
    @(negedge clk);
    check("t7_first_arb", 32'(mem_req), 1);
    check("t7_first_addr", mem_addr, 32'h100);
    wait_valid(1, 10, "t7_fetch_done");
    if_req = 0;

    repeat (4) @(negedge clk);
    check("drain_acc_q", 32'(acc_q.size()), 0);
    check("drain_rsp_q", 32'(rsp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: if_req input 1, fetch request; if_addr input 32, fetch address.
REQ-005 SHALL have ports: if_rdata output 32, fetched word; if_valid output 1, fetch-complete pulse.
REQ-006 SHALL have ports: d_req input 1, data request (load or store); d_we input 1, 1 = store; d_addr input 32; d_wdata input 32; d_wstrb input 4, byte enables.
REQ-007 SHALL have ports: d_rdata output 32, load data; d_valid output 1, data-complete pulse.
REQ-008 SHALL have port: stall  output  1  pipeline hold request.
REQ-009 SHALL have ports: mem_req output 1; mem_we output 1; mem_addr output 32; mem_wdata output 32; mem_wstrb output 4; mem_ready input 1; mem_rdata input 32. This is the single shared memory port.

Function
REQ-010 SHALL implement an FSM with states IDLE, BUSY_IF, BUSY_D.
REQ-011 In IDLE, at a rising edge with d_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT), SHALL latch d_we/d_addr/d_wdata/d_wstrb and go to BUSY_D.
REQ-012 In IDLE, at a rising edge with if_req=1 and (d_req=0 or starve_cnt==STARVE_LIMIT), SHALL latch if_addr with mem_we=0 and mem_wstrb=0, and go to BUSY_IF.
REQ-013 starve_cnt SHALL be wide enough for STARVE_LIMIT and behave as follows: +1 on a data grant while if_req=1 (saturating at STARVE_LIMIT); cleared on a fetch grant; cleared on a data grant while if_req=0.
REQ-014 In BUSY_IF/BUSY_D, mem_req SHALL be 1, and mem_we/mem_addr/mem_wdata/mem_wstrb SHALL be driven from the latched values and stay stable until completion.
REQ-015 Completion SHALL be mem_ready=1 sampled at a rising edge in a BUSY state. At that edge: capture mem_rdata into if_rdata or d_rdata, and return to IDLE.
REQ-016 The matching valid SHALL be 1 for exactly the one cycle after the completion edge. The rdata register SHALL hold its value until the next completion for that requester.
REQ-017 For a store completion, d_valid SHALL pulse and d_rdata SHALL be updated with mem_rdata (don't-care content).
REQ-018 mem_ready while in IDLE SHALL be ignored.
REQ-019 IDLE SHALL last at least one cycle between transactions. Minimum latency is 2 cycles: request sampled at edge N, mem_ready=1 at edge N+1, valid high in cycle N+2.
REQ-020 Deasserting a request after it has been granted SHALL NOT abort the transaction; valid still pulses.
REQ-021 A request deasserted before it is granted SHALL be treated as withdrawn, with no memory access.
REQ-022 stall SHALL be combinational: (d_req & ~d_valid) | (if_req & ~if_valid).
REQ-023 if_valid and d_valid SHALL never both be 1 in the same cycle.
REQ-024 The arbiter SHALL NOT impose any timeout; BUSY waits indefinitely for mem_ready.

Reset
REQ-025 On rst_n=0, immediately and independent of clk, the block SHALL set: state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no valid pulse. After rst_n rises, the first arbitration SHALL occur at the next rising edge.

Verification
REQ-027 Bench SHALL cover lone fetch: if_req=1, if_addr=0x100, mem_ready=1 the next cycle with mem_rdata=0x00500093 -> if_valid for 1 cycle, if_rdata=0x00500093, mem_we=0 throughout.
REQ-028 Bench SHALL cover simultaneous requests from reset: if_req=d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0xF -> data granted first with mem_we=1 and mem_addr=0x200; fetch granted after d_valid.
REQ-029 Bench SHALL cover starvation: if_req and d_req held at 1 continuously, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant, then data resumes.
REQ-030 Bench SHALL cover wait states: d_req load at 0x300, mem_ready held 0 for 5 cycles then 1 with mem_rdata=0x12345678 -> mem_addr stable for 6 cycles, stall=1 until d_valid, d_rdata=0x12345678.
REQ-031 Bench SHALL cover reset mid-operation: rst_n=0 while in BUSY_D -> mem_req=0 asynchronously, no d_valid pulse; after release, a fresh fetch completes normally.
REQ-032 Bench SHALL cover withdrawal: d_req pulsed for 1 cycle while BUSY_IF -> no data access issued, d_valid stays 0.
